// File: rtl/mem_resp_pkg.sv
// Shared definitions for the multi-cycle data-memory responder:
// FSM state encoding, default geometry/latency and the latency counter width.
package mem_resp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int DEF_LATENCY    = 4;
    localparam int DEF_DEPTH_LOG2 = 10;
    localparam int CNT_W          = 4;

endpackage

// File: rtl/mem_resp_array.sv
// Single-port synchronous word array with a registered read port.
// Contents and read register are intentionally unreset.
module mem_resp_array #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic                  re,
    input  logic [DEPTH_LOG2-1:0] idx,
    input  logic [15:0]           wd,
    output logic [15:0]           rd
);

    logic [15:0] mem [0:(1<<DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wd;
        end
        if (re) begin
            rd <= mem[idx];
        end
    end

endmodule

// File: rtl/mem_resp_ctl.sv
// Multi-cycle load/store responder: accepts one request at a time, stalls the
// processor for LATENCY-1 cycles and pulses done (and err for misaligned).
//
// Handshake: req is sampled only in IDLE or DONE (the accept edge); while
// stall is high the request inputs are ignored; done is a one-cycle pulse, and
// a new req presented during done is accepted on that same edge with no bubble.
module mem_resp_ctl
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        stall,
    output logic        done,
    output logic        err,
    output logic [1:0]  state_dbg
);

    state_t                state, state_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic                  wr_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [15:0]           wd_q;
    logic                  err_q;
    logic [15:0]           data_out_q;

    logic                  accept;
    logic                  arr_we, arr_re, load_done;
    logic [DEPTH_LOG2-1:0] arr_idx;
    logic [15:0]           arr_rd;

    // Upper address bits deliberately do not index the array (addresses wrap).
    logic                  unused_addr_hi;
    assign unused_addr_hi = ^addr[15:DEPTH_LOG2+1];

    assign accept = ((state == ST_IDLE) || (state == ST_DONE)) && req;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        arr_we    = 1'b0;
        arr_re    = 1'b0;
        arr_idx   = idx_q;
        load_done = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (req) begin
                    if (addr[0]) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_BUSY;
                        cnt_n   = CNT_W'(LATENCY - 2);
                        // Loads read the array on the accept edge; the word is
                        // moved into data_out when the latency expires.
                        arr_re  = ~wr;
                        arr_idx = addr[DEPTH_LOG2:1];
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CNT_W'(1);
                end else begin
                    state_n   = ST_DONE;
                    arr_we    = wr_q;
                    load_done = ~wr_q;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            wr_q       <= 1'b0;
            idx_q      <= '0;
            wd_q       <= '0;
            err_q      <= 1'b0;
            data_out_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            err_q <= accept && addr[0];
            if (accept) begin
                wr_q  <= wr;
                idx_q <= addr[DEPTH_LOG2:1];
                wd_q  <= data_in;
            end
            if (load_done) begin
                data_out_q <= arr_rd;
            end
        end
    end

    mem_resp_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk (clk),
        .we  (arr_we),
        .re  (arr_re),
        .idx (arr_idx),
        .wd  (wd_q),
        .rd  (arr_rd)
    );

    assign data_out  = data_out_q;
    assign stall     = (state == ST_BUSY);
    assign done      = (state == ST_DONE);
    assign err       = err_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_mem_resp_ctl.sv
// Self-checking bench for mem_resp_ctl: directed scenarios plus randomized
// load/store traffic against a word-array reference model.
module tb_mem_resp_ctl;

    localparam int LAT = 4;
    localparam int DL2 = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        stall;
    logic        done;
    logic        err;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem_model [0:(1<<DL2)-1];
    logic [15:0] exp_dout;
    logic [15:0] exp_q[$];
    logic [15:0] written_q[$];

    mem_resp_ctl #(
        .DEPTH_LOG2(DL2),
        .LATENCY   (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .wr        (wr),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Word index selected by a byte address: byte addresses wrap at 2^(DL2+1).
    function automatic int widx(input logic [15:0] a);
        return (int'(a) % (1 << (DL2 + 1))) / 2;
    endfunction

    // Presents one request just after an edge and observes it until done.
    // Returns inside the done cycle (1 time unit after the edge).
    task automatic run_op(input logic w, input logic [15:0] a, input logic [15:0] d,
                          output int n_stall, output int done_k, output int n_err_bad,
                          output logic err_at_done, output logic [15:0] dout_at_done);
        n_stall = 0;
        done_k = -1;
        n_err_bad = 0;
        err_at_done = 1'b0;
        dout_at_done = '0;
        req = 1'b1;
        wr = w;
        addr = a;
        data_in = d;
        @(posedge clk);
        #1;
        for (int k = 1; k <= LAT + 3 && done_k < 0; k++) begin
            if (stall) n_stall++;
            if (err && !done) n_err_bad++;
            if (done) begin
                done_k = k;
                err_at_done = err;
                dout_at_done = data_out;
            end else begin
                req = 1'($urandom_range(0, 1));
                wr = 1'($urandom_range(0, 1));
                addr = 16'($urandom);
                data_in = 16'($urandom);
                @(posedge clk);
                #1;
            end
        end
        if (done_k < 0) req = 1'b0;
    endtask

    task automatic idle_gap(input int n, output int bad);
        bad = 0;
        req = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (stall || done || err || data_out !== exp_dout) bad++;
        end
    endtask

    // Reference model: applies the architectural effect of a completed request.
    task automatic model_apply(input logic w, input logic [15:0] a, input logic [15:0] d);
        if (a[0]) return;
        if (w) begin
            mem_model[widx(a)] = d;
            written_q.push_back(a);
        end else begin
            exp_dout = mem_model[widx(a)];
        end
    endtask

    task automatic test_reset;
        int bad;
        rst = 1'b0;
        req = 1'b0;
        wr = 1'b0;
        addr = '0;
        data_in = '0;
        exp_dout = '0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if ({stall, done, err} !== 3'b000 || data_out !== 16'h0000 || state_dbg !== 2'b00) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: stall=%b done=%b err=%b data_out=%h state=%b, required all 0",
                         i, stall, done, err, data_out, state_dbg);
            end
        end
        rst = 1'b1;
        idle_gap(4, bad);
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL reset_idle: %0d bad idle cycles, required 0", bad);
        end
    endtask

    task automatic test_store_load;
        int ns, dk, eb, bad;
        logic ed;
        logic [15:0] dd;
        run_op(1'b1, 16'h0010, 16'hBEEF, ns, dk, eb, ed, dd);
        model_apply(1'b1, 16'h0010, 16'hBEEF);
        n_checks++;
        if (ns !== LAT - 1 || dk !== LAT || ed !== 1'b0 || eb !== 0) begin
            n_fail++;
            $display("FAIL store_timing: stall=%0d done_at=%0d err=%b, required stall=%0d done_at=%0d err=0",
                     ns, dk, ed, LAT - 1, LAT);
        end
        idle_gap(2, bad);
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL store_idle: %0d bad cycles, required 0", bad);
        end
        run_op(1'b0, 16'h0010, 16'h0000, ns, dk, eb, ed, dd);
        model_apply(1'b0, 16'h0010, 16'h0000);
        n_checks++;
        if (ns !== LAT - 1 || dk !== LAT || ed !== 1'b0 || dd !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL load_beef: stall=%0d done_at=%0d err=%b data=%h, required stall=%0d done_at=%0d err=0 data=beef",
                     ns, dk, ed, dd, LAT - 1, LAT);
        end
        idle_gap(3, bad);
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL load_hold: %0d bad cycles (data_out=%h), required 0", bad, data_out);
        end
    endtask

    task automatic test_back_to_back;
        int ns, dk, eb, bad;
        logic ed;
        logic [15:0] dd;
        run_op(1'b1, 16'h0020, 16'h1234, ns, dk, eb, ed, dd);
        model_apply(1'b1, 16'h0020, 16'h1234);
        n_checks++;
        if (dk !== LAT) begin
            n_fail++;
            $display("FAIL b2b_store: done_at=%0d, required %0d", dk, LAT);
        end
        run_op(1'b0, 16'h0020, 16'h0000, ns, dk, eb, ed, dd);
        model_apply(1'b0, 16'h0020, 16'h0000);
        n_checks++;
        if (ns !== LAT - 1 || dk !== LAT || dd !== 16'h1234) begin
            n_fail++;
            $display("FAIL b2b_load: stall=%0d done_at=%0d data=%h, required stall=%0d done_at=%0d data=1234",
                     ns, dk, dd, LAT - 1, LAT);
        end
        idle_gap(2, bad);
    endtask

    task automatic test_misaligned;
        int ns, dk, eb, bad;
        logic ed;
        logic [15:0] dd;
        run_op(1'b0, 16'h0011, 16'h0000, ns, dk, eb, ed, dd);
        n_checks++;
        if (ns !== 0 || dk !== 1 || ed !== 1'b1 || dd !== exp_dout) begin
            n_fail++;
            $display("FAIL misaligned: stall=%0d done_at=%0d err=%b data=%h, required stall=0 done_at=1 err=1 data=%h",
                     ns, dk, ed, dd, exp_dout);
        end
        idle_gap(2, bad);
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL misaligned_after: %0d bad cycles, required 0", bad);
        end
    endtask

    task automatic test_wrap;
        int ns, dk, eb, bad;
        logic ed;
        logic [15:0] dd;
        run_op(1'b1, 16'h0802, 16'hA5A5, ns, dk, eb, ed, dd);
        model_apply(1'b1, 16'h0802, 16'hA5A5);
        idle_gap(1, bad);
        run_op(1'b0, 16'h0002, 16'h0000, ns, dk, eb, ed, dd);
        model_apply(1'b0, 16'h0002, 16'h0000);
        n_checks++;
        if (dk !== LAT || dd !== 16'hA5A5) begin
            n_fail++;
            $display("FAIL wrap: done_at=%0d data=%h, required done_at=%0d data=a5a5", dk, dd, LAT);
        end
        idle_gap(1, bad);
    endtask

    task automatic test_reset_midop;
        int ns, dk, eb, bad;
        logic ed;
        logic [15:0] dd;
        run_op(1'b1, 16'h0030, 16'h0000, ns, dk, eb, ed, dd);
        model_apply(1'b1, 16'h0030, 16'h0000);
        idle_gap(1, bad);
        req = 1'b1;
        wr = 1'b1;
        addr = 16'h0030;
        data_in = 16'hFFFF;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_dout = '0;
        #1;
        n_checks++;
        if ({stall, done, err} !== 3'b000 || data_out !== 16'h0000 || state_dbg !== 2'b00) begin
            n_fail++;
            $display("FAIL midop_reset: stall=%b done=%b err=%b data_out=%h state=%b, required all 0",
                     stall, done, err, data_out, state_dbg);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        idle_gap(2, bad);
        run_op(1'b0, 16'h0030, 16'h0000, ns, dk, eb, ed, dd);
        model_apply(1'b0, 16'h0030, 16'h0000);
        n_checks++;
        if (dk !== LAT || dd !== 16'h0000) begin
            n_fail++;
            $display("FAIL midop_load: done_at=%0d data=%h, required done_at=%0d data=0000", dk, dd, LAT);
        end
        idle_gap(1, bad);
    endtask

    task automatic test_random;
        int ns, dk, eb, bad, gap;
        logic ed, w, mis;
        logic [15:0] a, d, exp_d;
        for (int n = 0; n < 60; n++) begin
            mis = ($urandom_range(0, 7) == 0);
            w = 1'($urandom_range(0, 1));
            if (written_q.size() == 0) w = 1'b1;
            d = 16'($urandom);
            if (w) begin
                a = 16'($urandom) & 16'hFFFE;
            end else begin
                a = written_q[$urandom_range(0, written_q.size() - 1)] ^ (16'($urandom) & 16'hF800);
            end
            if (mis) a = a | 16'h0001;
            if (!w && !mis) exp_q.push_back(mem_model[widx(a)]);
            run_op(w, a, d, ns, dk, eb, ed, exp_d);
            model_apply(w, a, d);
            n_checks++;
            if (ns !== (mis ? 0 : LAT - 1) || dk !== (mis ? 1 : LAT) || ed !== mis || eb !== 0) begin
                n_fail++;
                $display("FAIL rand_timing op%0d wr=%b addr=%h: stall=%0d done_at=%0d err=%b, required stall=%0d done_at=%0d err=%b",
                         n, w, a, ns, dk, ed, mis ? 0 : LAT - 1, mis ? 1 : LAT, mis);
            end
            if (!w && !mis) begin
                logic [15:0] want;
                want = exp_q.pop_front();
                n_checks++;
                if (exp_d !== want) begin
                    n_fail++;
                    $display("FAIL rand_load op%0d addr=%h: data=%h, required %h", n, a, exp_d, want);
                end
            end else begin
                n_checks++;
                if (exp_d !== exp_dout) begin
                    n_fail++;
                    $display("FAIL rand_hold op%0d addr=%h: data=%h, required %h", n, a, exp_d, exp_dout);
                end
            end
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                idle_gap(gap, bad);
                n_checks++;
                if (bad !== 0) begin
                    n_fail++;
                    $display("FAIL rand_idle op%0d: %0d bad cycles, required 0", n, bad);
                end
            end
        end
        idle_gap(1, bad);
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_back_to_back();
        test_misaligned();
        test_wrap();
        test_reset_midop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
